pixel_point_op: RTL and testbench

Streaming per-pixel point-operation engine for the image pipeline. It generalises the single-byte brighten/darken/binarise datapath to CH channels of PIX_W bits each, and adds invert and pass-through modes. It adds valid/ready flow control, frame-synchronous configuration latching and a per-frame beat counter. It sits between the pixel source (file/BRAM reader) and any downstream filter or output writer.

---
 rtl/img_pkg.sv | 28 ++
 rtl/pix_alu.sv | 30 +++
 rtl/pixel_point_op.sv | 151 +++++++++++++++
 tb/tb_pixel_point_op.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the pixel point-operation engine: mode encodings
// and width-generic saturating arithmetic helpers.
package img_pkg;

    typedef enum logic [2:0] {
        MODE_PASS     = 3'd0,
        MODE_BRIGHTEN = 3'd1,
        MODE_DARKEN   = 3'd2,
        MODE_BINARISE = 3'd3,
        MODE_INVERT   = 3'd4
    } pix_mode_e;

    // Operands are zero-extended samples; the 32-bit sum cannot overflow for any
    // sample width up to 31 bits, so clamping against max_v is exact.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [31:0] sum;
        sum = a + b;
        return (sum > max_v) ? max_v : sum;
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/pix_alu.sv
// Single-channel combinational point operation: maps one sample x to y
// according to the selected mode, offset and threshold.
module pix_alu
    import img_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [2:0]       mode_i,
    input  logic [PIX_W-1:0] value_i,
    input  logic [PIX_W-1:0] thresh_i,
    input  logic [PIX_W-1:0] x_i,
    output logic [PIX_W-1:0] y_o
);

    localparam logic [31:0] PIX_MAX = 32'((64'd1 << PIX_W) - 64'd1);

    // Undefined encodings fall through to pass-through.
    always_comb begin
        y_o = x_i;
        case (mode_i)
            MODE_PASS:     y_o = x_i;
            MODE_BRIGHTEN: y_o = PIX_W'(sat_add(32'(x_i), 32'(value_i), PIX_MAX));
            MODE_DARKEN:   y_o = PIX_W'(sat_sub(32'(x_i), 32'(value_i)));
            MODE_BINARISE: y_o = (x_i >= thresh_i) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
            MODE_INVERT:   y_o = ~x_i;
            default:       y_o = x_i;
        endcase
    end

endmodule

// File: rtl/pixel_point_op.sv
// Streaming per-pixel point-operation engine: two-stage valid/ready pipeline,
// configuration latched on SOF beats, per-frame output beat counter.
module pixel_point_op
    import img_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int CH    = 1,
    parameter int CNT_W = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            cfg_mode,
    input  logic [PIX_W-1:0]      cfg_value,
    input  logic [PIX_W-1:0]      cfg_thresh,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [CH*PIX_W-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic [CH*PIX_W-1:0]   out_data,
    output logic [CNT_W-1:0]      out_count
);

    localparam int DW = CH * PIX_W;

    logic [2:0]       cfg_mode_q,   cfg_mode_d;
    logic [PIX_W-1:0] cfg_value_q,  cfg_value_d;
    logic [PIX_W-1:0] cfg_thresh_q, cfg_thresh_d;

    logic             s1_valid_q,  s1_valid_d;
    logic             s1_sof_q,    s1_sof_d;
    logic [DW-1:0]    s1_data_q,   s1_data_d;
    logic [2:0]       s1_mode_q,   s1_mode_d;
    logic [PIX_W-1:0] s1_value_q,  s1_value_d;
    logic [PIX_W-1:0] s1_thresh_q, s1_thresh_d;

    logic             out_valid_q, out_valid_d;
    logic             out_sof_q,   out_sof_d;
    logic [DW-1:0]    out_data_q,  out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             advance_s;
    logic             accept_s;
    logic [DW-1:0]    alu_y_s;

    assign advance_s = out_ready | ~out_valid_q;
    assign accept_s  = in_valid & advance_s;
    assign in_ready  = advance_s;

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        pix_alu #(.PIX_W(PIX_W)) u_alu (
            .mode_i   (s1_mode_q),
            .value_i  (s1_value_q),
            .thresh_i (s1_thresh_q),
            .x_i      (s1_data_q[c*PIX_W +: PIX_W]),
            .y_o      (alu_y_s[c*PIX_W +: PIX_W])
        );
    end

    // Next-state: an SOF beat carries the fresh cfg_* into S1 directly so the
    // mode switches exactly at that beat; other beats use the latched config.
    always_comb begin
        cfg_mode_d   = cfg_mode_q;
        cfg_value_d  = cfg_value_q;
        cfg_thresh_d = cfg_thresh_q;
        s1_valid_d   = s1_valid_q;
        s1_sof_d     = s1_sof_q;
        s1_data_d    = s1_data_q;
        s1_mode_d    = s1_mode_q;
        s1_value_d   = s1_value_q;
        s1_thresh_d  = s1_thresh_q;
        out_valid_d  = out_valid_q;
        out_sof_d    = out_sof_q;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;

        if (accept_s && in_sof) begin
            cfg_mode_d   = cfg_mode;
            cfg_value_d  = cfg_value;
            cfg_thresh_d = cfg_thresh;
        end else begin
            cfg_mode_d   = cfg_mode_q;
        end

        if (advance_s) begin
            s1_valid_d  = in_valid;
            out_valid_d = s1_valid_q;
            if (in_valid) begin
                s1_sof_d    = in_sof;
                s1_data_d   = in_data;
                s1_mode_d   = in_sof ? cfg_mode   : cfg_mode_q;
                s1_value_d  = in_sof ? cfg_value  : cfg_value_q;
                s1_thresh_d = in_sof ? cfg_thresh : cfg_thresh_q;
            end else begin
                s1_sof_d    = s1_sof_q;
            end
            // out_count_q still holds the last emitted beat's index here.
            if (s1_valid_q) begin
                out_sof_d   = s1_sof_q;
                out_data_d  = alu_y_s;
                out_count_d = s1_sof_q ? {CNT_W{1'b0}}
                                       : out_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                out_sof_d   = out_sof_q;
            end
        end else begin
            s1_valid_d  = s1_valid_q;
        end
    end

    // State registers; reset discards in-flight beats and restores PASS config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_mode_q   <= MODE_PASS;
            cfg_value_q  <= {PIX_W{1'b0}};
            cfg_thresh_q <= {PIX_W{1'b0}};
            s1_valid_q   <= 1'b0;
            s1_sof_q     <= 1'b0;
            s1_data_q    <= {DW{1'b0}};
            s1_mode_q    <= MODE_PASS;
            s1_value_q   <= {PIX_W{1'b0}};
            s1_thresh_q  <= {PIX_W{1'b0}};
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_data_q   <= {DW{1'b0}};
            out_count_q  <= {CNT_W{1'b0}};
        end else begin
            cfg_mode_q   <= cfg_mode_d;
            cfg_value_q  <= cfg_value_d;
            cfg_thresh_q <= cfg_thresh_d;
            s1_valid_q   <= s1_valid_d;
            s1_sof_q     <= s1_sof_d;
            s1_data_q    <= s1_data_d;
            s1_mode_q    <= s1_mode_d;
            s1_value_q   <= s1_value_d;
            s1_thresh_q  <= s1_thresh_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
        end
    end

endmodule

// File: tb/tb_pixel_point_op.sv
// Scoreboard bench for pixel_point_op (PIX_W=8, CH=3): directed cases from the
// test plan followed by randomized traffic with random backpressure.
module tb_pixel_point_op;

    localparam int PIX_W = 8;
    localparam int CH    = 3;
    localparam int CNT_W = 20;
    localparam int DW    = CH * PIX_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       cfg_mode = 3'd0;
    logic [PIX_W-1:0] cfg_value = 8'd0;
    logic [PIX_W-1:0] cfg_thresh = 8'd0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sof = 1'b0;
    logic [DW-1:0]    in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_sof;
    logic [DW-1:0]    out_data;
    logic [CNT_W-1:0] out_count;

    pixel_point_op #(.PIX_W(PIX_W), .CH(CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_mode(cfg_mode), .cfg_value(cfg_value), .cfg_thresh(cfg_thresh),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
        .out_data(out_data), .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          sof;
        int            cnt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   lat_acc = 0;
    int   lat_req = 0;
    int   lat_done = 0;
    bit   stall   = 1'b0;
    bit   rand_bp = 1'b0;

    // Reference model state: active config and last emitted index.
    int   m_mode = 0, m_val = 0, m_thr = 0, m_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: forced low during a stall window, else random or 1.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (stall) out_ready = 1'b0;
            else if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
        end
    end

    function automatic logic [DW-1:0] ref_beat(int mode, int val, int thr, logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            int x, y;
            x = int'(d[c*PIX_W +: PIX_W]);
            case (mode)
                1:       y = (x + val > 255) ? 255 : x + val;
                2:       y = (x - val < 0) ? 0 : x - val;
                3:       y = (x >= thr) ? 255 : 0;
                4:       y = 255 - x;
                default: y = x;
            endcase
            r[c*PIX_W +: PIX_W] = 8'(y);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_sof;
    logic [CNT_W-1:0] hold_cnt;

    // Monitor: samples on the falling edge, pops and compares on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_data",  64'(out_data),  64'd0);
            chk("rst_out_count", 64'(out_count), 64'd0);
            q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data",  64'(out_data),  64'(hold_data));
                chk("hold_sof",   64'(out_sof),   64'(hold_sof));
                chk("hold_count", 64'(out_count), 64'(hold_cnt));
            end
            if (out_valid && !out_ready) begin
                chk("in_ready_stall", 64'(in_ready), 64'd0);
                hold_v = 1'b1;
                hold_data = out_data;
                hold_sof = out_sof;
                hold_cnt = out_count;
            end else begin
                hold_v = 1'b0;
            end
            if (!out_valid) chk("in_ready_idle", 64'(in_ready), 64'd1);
            if (lat_req != lat_done && out_valid) begin
                chk("latency", 64'(cyc - lat_acc), 64'd2);
                lat_done = lat_req;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_beat: got data %0h with no beat expected", out_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data",  64'(out_data),  64'(e.data));
                    chk("out_sof",   64'(out_sof),   64'(e.sof));
                    chk("out_count", 64'(out_count), 64'(e.cnt));
                end
            end
        end
    end

    // Presents one beat (called at posedge+1) and holds it until accepted.
    task automatic send(input logic [DW-1:0] d, input logic sof, input logic [2:0] mode,
                        input logic [7:0] v, input logic [7:0] t);
        bit done;
        exp_t e;
        done = 1'b0;
        in_valid = 1'b1; in_data = d; in_sof = sof;
        cfg_mode = mode; cfg_value = v; cfg_thresh = t;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                if (sof) begin
                    m_mode = int'(mode); m_val = int'(v); m_thr = int'(t);
                end
                e.data = ref_beat(m_mode, m_val, m_thr, d);
                e.sof  = sof;
                e.cnt  = sof ? 0 : ((m_prev + 1) % (1 << CNT_W));
                m_prev = e.cnt;
                q.push_back(e);
                acc_cyc = cyc;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
        if (!done) begin
            $display("FAIL accept_timeout: in_ready never rose for beat %0h", d);
            $fatal(1, "accept timeout");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ch0(input logic [7:0] x);
        logic [DW-1:0] r;
        r = DW'($urandom);
        r[7:0] = x;
        return r;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Brighten with latency check on the first beat.
        send(ch0(8'h10), 1'b1, 3'd1, 8'h40, 8'h00);
        lat_acc = acc_cyc;
        lat_req = lat_req + 1;
        idle(4);
        send(ch0(8'hF0), 1'b0, 3'd2, 8'h11, 8'h00);
        idle(3);

        // Darken, then invert.
        send(ch0(8'h20), 1'b1, 3'd2, 8'h40, 8'h00);
        send(ch0(8'h80), 1'b0, 3'd0, 8'h00, 8'h00);
        send(ch0(8'h3C), 1'b1, 3'd4, 8'h00, 8'h00);
        idle(3);

        // Binarise across three channels; mid-frame mode change is ignored.
        send({8'hFF, 8'h82, 8'h81}, 1'b1, 3'd3, 8'h00, 8'h82);
        send({8'h00, 8'h90, 8'h10}, 1'b0, 3'd4, 8'h00, 8'h00);
        send({8'h82, 8'h81, 8'h83}, 1'b0, 3'd4, 8'h00, 8'h00);
        send({8'h12, 8'h34, 8'h56}, 1'b1, 3'd4, 8'h00, 8'h00);
        send({8'hAB, 8'hCD, 8'hEF}, 1'b0, 3'd0, 8'h00, 8'h00);
        send({8'h00, 8'hFF, 8'h01}, 1'b0, 3'd1, 8'h55, 8'h00);
        idle(4);

        // Eight-beat stream with a three-cycle downstream stall.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(DW'($urandom), (i == 0), 3'd1, 8'h20, 8'h00);
            end
            begin
                for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
                @(posedge clk);
                #1;
                stall = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                stall = 1'b0;
            end
        join
        idle(6);

        // Reset with two beats in flight; config must return to PASS.
        send(ch0(8'h11), 1'b1, 3'd4, 8'h00, 8'h00);
        send(ch0(8'h22), 1'b0, 3'd4, 8'h00, 8'h00);
        rst = 1'b1;
        m_mode = 0; m_val = 0; m_thr = 0; m_prev = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        send({8'h01, 8'h7F, 8'hC8}, 1'b0, 3'd4, 8'h10, 8'h10);
        idle(4);

        // Randomized traffic with backpressure, gaps and frame restarts.
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(DW'($urandom), (i == 0) || ($urandom_range(0, 11) == 0),
                 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rand_bp = 1'b0;

        for (int k = 0; k < 2000 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain_timeout: %0d beats never emitted", q.size());
            $fatal(1, "drain timeout");
        end
        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
